// File: rtl/logical_tile_io_bank.sv
// Multi-channel GPIO tile at the fabric edge. Each channel is configured through the bl/wl
// memory-bank interface and can act as an input, an output or a bidirectional pad.
module logical_tile_io_bank #(
  parameter int NUM_IO      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CFG_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CFG_W-1:0]  bl,
  input  logic [NUM_IO-1:0] wl,
  input  logic [NUM_IO-1:0] io_outpad,
  input  logic [NUM_IO-1:0] io_oe,
  output logic [NUM_IO-1:0] io_inpad,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD
);

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeIn    = 2'b01,
    ModeOut   = 2'b10,
    ModeBidir = 2'b11
  } mode_e;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    logic [CFG_W-1:0]       cfg_q;
    logic [SYNC_STAGES-1:0] sync_q;
    mode_e                  mode;
    logic                   in_reg;
    logic                   out_reg;
    logic                   in_en;
    logic                   pad_in;
    logic                   oe_comb;
    logic                   oe_q;
    logic                   dout_q;
    logic                   oe;
    logic                   dout;

    assign mode    = mode_e'(cfg_q[1:0]);
    assign in_reg  = cfg_q[2];
    assign out_reg = cfg_q[3];
    assign in_en   = (mode == ModeIn) || (mode == ModeBidir);
    assign pad_in  = gfpga_pad_GPIO_PAD[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cfg_q <= '0;
      end else if (wl[i]) begin
        cfg_q <= bl;
      end
    end

    // A config write clears the chain on the same edge so no stale sample survives a mode change.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
      end else if (wl[i] || !(in_en && in_reg)) begin
        sync_q <= '0;
      end else if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      end else begin
        sync_q <= pad_in;
      end
    end

    always_comb begin
      oe_comb = 1'b0;
      unique case (mode)
        ModeOut:   oe_comb = 1'b1;
        ModeBidir: oe_comb = io_oe[i];
        default:   oe_comb = 1'b0;
      endcase
    end

    // Data and enable are registered together so a registered pad never glitches between them.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        oe_q   <= 1'b0;
        dout_q <= 1'b0;
      end else if (wl[i]) begin
        oe_q   <= 1'b0;
        dout_q <= 1'b0;
      end else begin
        oe_q   <= oe_comb;
        dout_q <= io_outpad[i];
      end
    end

    assign oe   = out_reg ? oe_q : oe_comb;
    assign dout = out_reg ? dout_q : io_outpad[i];

    assign gfpga_pad_GPIO_PAD[i] = oe ? dout : 1'bz;
    assign io_inpad[i] = in_en ? (in_reg ? sync_q[SYNC_STAGES-1] : pad_in) : 1'b0;
  end

endmodule
